compound_link_initiator: RTL and testbench

- Initiator side of the CompoundType sync/notify link. Drives the request channel into a responder's blocking input port and takes responses from that responder's blocking output port.
- Host commands are buffered in a small FIFO and offered one at a time on the request channel.
- Read requests are tracked as outstanding until a response returns; write requests are posted and never tracked.
- Responses are held in a one-entry register for the host.

---
 rtl/compound_link_initiator_pkg.sv | 30 +++
 rtl/compound_link_initiator_fifo.sv | 61 ++++++
 rtl/compound_link_initiator.sv | 145 ++++++++++++++
 tb/tb_compound_link_initiator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compound_link_initiator_pkg.sv
// Shared link types. Both ends of the CompoundType sync/notify link import
// this package so the payload layout is defined in exactly one place.
package testbasic15_types;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e              mode;
        logic signed [31:0] x;
        logic               y;
    } CompoundType;

    // Send-side section of the initiator.
    typedef enum logic {
        SEC_IDLE  = 1'b0,
        SEC_OFFER = 1'b1
    } InitSection;

    localparam CompoundType COMPOUND_RESET = '{mode: read, x: 32'sd0, y: 1'b0};

    // A queued command may be issued if it is a posted write, or if there
    // is still room for another tracked read.
    function automatic logic can_issue(input CompoundType head, input logic read_room);
        return (head.mode == write) || read_room;
    endfunction

endpackage

// File: rtl/compound_link_initiator_fifo.sv
// Small command FIFO for CompoundType payloads. Head entry is visible
// combinationally; push is ignored when full and pop is ignored when empty.
module compound_fifo
    import testbasic15_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  CompoundType push_data,
    input  logic        pop,
    output CompoundType head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    CompoundType     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_en;
    logic            pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en && !pop_en) begin
                count <= count + 1'b1;
            end else if (!push_en && pop_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/compound_link_initiator.sv
// Initiator end of the CompoundType sync/notify link: buffers host commands,
// offers them on the request channel, tracks outstanding reads and holds
// returned responses for the host.
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// notify and sync are both 1. Each side drives its own signal independently;
// neither waits for the other's signal before asserting its own, and an
// offered request stays stable until it is taken.
module compound_link_initiator
    import testbasic15_types::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  CompoundType                  cmd_data,
    output CompoundType                  req,
    output logic                         req_notify,
    input  logic                         req_sync,
    input  CompoundType                  rsp,
    input  logic                         rsp_sync,
    output logic                         rsp_notify,
    output logic                         rsp_valid,
    output CompoundType                  rsp_data,
    input  logic                         rsp_ready,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         proto_err,
    output InitSection                   section
);

    localparam int               OW        = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0]    MAX_OUT_W = OW'(MAX_OUT);

    InitSection     state;
    InitSection     state_next;
    CompoundType    fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           req_done;
    logic           read_done;
    logic           rsp_accept;
    logic           rsp_dec;
    logic [OW-1:0]  out_next;

    assign cmd_ready  = !fifo_full;
    assign req_notify = (state == SEC_OFFER);
    assign section    = state;
    assign rsp_notify = !rsp_valid || rsp_ready;
    assign rsp_accept = rsp_sync && rsp_notify;
    assign req_done   = req_notify && req_sync;
    assign read_done  = req_done && (req.mode == read);
    assign rsp_dec    = rsp_accept && (outstanding != '0);

    compound_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outstanding count after this edge; used so a reload in SEC_OFFER never
    // lets the tracked reads exceed MAX_OUT.
    always_comb begin
        out_next = outstanding;
        if (read_done && !rsp_dec) begin
            out_next = outstanding + 1'b1;
        end else if (!read_done && rsp_dec) begin
            out_next = outstanding - 1'b1;
        end
    end

    // Send FSM next-state and FIFO pop decision.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            SEC_IDLE: begin
                if (!fifo_empty && can_issue(fifo_head, outstanding < MAX_OUT_W)) begin
                    fifo_pop   = 1'b1;
                    state_next = SEC_OFFER;
                end
            end
            SEC_OFFER: begin
                if (req_done) begin
                    if (!fifo_empty && can_issue(fifo_head, out_next < MAX_OUT_W)) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_next = SEC_IDLE;
                    end
                end
            end
            default: state_next = SEC_IDLE;
        endcase
    end

    // Send FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request payload loads whenever the head is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req <= COMPOUND_RESET;
        end else if (fifo_pop) begin
            req <= fifo_head;
        end
    end

    // Response holding register, outstanding-read counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= COMPOUND_RESET;
            outstanding <= '0;
            proto_err   <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (rsp_accept) begin
                rsp_data  <= rsp;
                rsp_valid <= 1'b1;
                if ((outstanding == '0) || (rsp.mode != read)) begin
                    proto_err <= 1'b1;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_compound_link_initiator.sv
// Directed bench for compound_link_initiator. Expected request and response
// transfers go into queues when stimulus is issued; a negedge monitor pops
// and compares whenever a transfer is about to complete.
module tb_compound_link_initiator;
    import testbasic15_types::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    CompoundType cmd_data;
    CompoundType req;
    logic        req_notify;
    logic        req_sync;
    CompoundType rsp;
    logic        rsp_sync;
    logic        rsp_notify;
    logic        rsp_valid;
    CompoundType rsp_data;
    logic        rsp_ready;
    logic [2:0]  outstanding;
    logic        proto_err;
    InitSection  section;

    logic [33:0] exp_req_q[$];
    logic [33:0] exp_rsp_q[$];
    int          applied    = 0;
    int          miscompares = 0;

    compound_link_initiator #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .req         (req),
        .req_notify  (req_notify),
        .req_sync    (req_sync),
        .rsp         (rsp),
        .rsp_sync    (rsp_sync),
        .rsp_notify  (rsp_notify),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .outstanding (outstanding),
        .proto_err   (proto_err),
        .section     (section)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic CompoundType mk(input mode_e m, input int x, input logic y);
        CompoundType c;
        c.mode = m;
        c.x    = x;
        c.y    = y;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for one edge; optionally record it as expected traffic.
    task automatic drive_cmd(input CompoundType c, input bit track);
        cmd_valid = 1'b1;
        cmd_data  = c;
        if (track) exp_req_q.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Present one response on the response channel (held until changed).
    task automatic drive_rsp(input CompoundType c);
        rsp_sync = 1'b1;
        rsp      = c;
        exp_rsp_q.push_back(c);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst) begin
            if (req_notify && req_sync) begin
                if (exp_req_q.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL req_xfer: got unexpected %h required none", req);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_xfer", 64'(req), 64'(e));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL rsp_out: got unexpected %h required none", rsp_data);
                end else begin
                    e = exp_rsp_q.pop_front();
                    chk("rsp_out", 64'(rsp_data), 64'(e));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        CompoundType a [5];
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = COMPOUND_RESET;
        req_sync  = 1'b0;
        rsp       = COMPOUND_RESET;
        rsp_sync  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_req_notify", 64'(req_notify), 64'd0);
        chk("rst_req", 64'(req), 64'(COMPOUND_RESET));
        chk("rst_rsp_notify", 64'(rsp_notify), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'(COMPOUND_RESET));
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b0;

        // 1: single read, latency of two edges
        req_sync = 1'b1;
        drive_cmd(mk(read, 5, 1'b1), 1'b1);
        chk("t1_notify_edge1", 64'(req_notify), 64'd0);
        tick();
        chk("t1_notify_edge2", 64'(req_notify), 64'd1);
        chk("t1_req", 64'(req), 64'(mk(read, 5, 1'b1)));
        tick();
        chk("t1_outstanding", 64'(outstanding), 64'd1);
        chk("t1_notify_drop", 64'(req_notify), 64'd0);
        drive_rsp(mk(read, 11, 1'b1));
        tick();
        rsp_sync = 1'b0;
        chk("t1_rsp_clears", 64'(outstanding), 64'd0);
        tick();

        // 2: four reads held off, then back-to-back; fifth read stalls
        req_sync = 1'b0;
        for (int i = 0; i < 5; i++) a[i] = mk(read, 100 + i, 1'(i));
        drive_cmd(a[0], 1'b1);
        for (int i = 1; i < 5; i++) begin
            drive_cmd(a[i], 1'b1);
            chk("t2_hold_notify", 64'(req_notify), 64'd1);
            chk("t2_hold_req", 64'(req), 64'(a[0]));
            if (i == 3) chk("t2_ready_3q", 64'(cmd_ready), 64'd1);
            if (i == 4) chk("t2_full", 64'(cmd_ready), 64'd0);
        end
        req_sync = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t2_outstanding", 64'(outstanding), 64'(k));
        end
        chk("t2_stall_notify", 64'(req_notify), 64'd0);
        tick();
        chk("t2_stall_notify2", 64'(req_notify), 64'd0);
        chk("t2_stall_out", 64'(outstanding), 64'd4);

        // Free one slot so the stalled read issues
        drive_rsp(mk(read, 12, 1'b0));
        tick();
        rsp_sync = 1'b0;
        chk("t2_rsp_dec", 64'(outstanding), 64'd3);
        tick();
        chk("t2_a4_notify", 64'(req_notify), 64'd1);
        chk("t2_a4_req", 64'(req), 64'(a[4]));
        tick();
        chk("t2_a4_out", 64'(outstanding), 64'd4);
        chk("t2_a4_done", 64'(req_notify), 64'd0);

        // 3: write at head with outstanding at max, response on same edge
        req_sync = 1'b0;
        drive_cmd(mk(write, -7, 1'b1), 1'b1);
        tick();
        chk("t3_write_notify", 64'(req_notify), 64'd1);
        chk("t3_write_req", 64'(req), 64'(mk(write, -7, 1'b1)));
        chk("t3_out_before", 64'(outstanding), 64'd4);
        req_sync = 1'b1;
        drive_rsp(mk(read, 13, 1'b1));
        tick();
        rsp_sync = 1'b0;
        chk("t3_out_after", 64'(outstanding), 64'd3);
        chk("t3_notify_drop", 64'(req_notify), 64'd0);
        tick();

        // 4: holding register back-pressure
        rsp_ready = 1'b0;
        drive_rsp(mk(read, 14, 1'b0));
        tick();
        drive_rsp(mk(read, 15, 1'b1));
        chk("t4_valid", 64'(rsp_valid), 64'd1);
        chk("t4_notify_low", 64'(rsp_notify), 64'd0);
        chk("t4_data_first", 64'(rsp_data), 64'(mk(read, 14, 1'b0)));
        chk("t4_out_first", 64'(outstanding), 64'd2);
        tick();
        chk("t4_data_held", 64'(rsp_data), 64'(mk(read, 14, 1'b0)));
        chk("t4_out_held", 64'(outstanding), 64'd2);
        rsp_ready = 1'b1;
        #1;
        chk("t4_notify_pass", 64'(rsp_notify), 64'd1);
        tick();
        rsp_sync = 1'b0;
        chk("t4_data_second", 64'(rsp_data), 64'(mk(read, 15, 1'b1)));
        chk("t4_out_second", 64'(outstanding), 64'd1);
        tick();

        // 5: response with nothing outstanding
        drive_rsp(mk(read, 16, 1'b0));
        tick();
        chk("t5_err_clean", 64'(proto_err), 64'd0);
        chk("t5_out_zero", 64'(outstanding), 64'd0);
        drive_rsp(mk(read, 9, 1'b0));
        tick();
        rsp_sync = 1'b0;
        chk("t5_err_set", 64'(proto_err), 64'd1);
        chk("t5_out_stays", 64'(outstanding), 64'd0);
        chk("t5_valid", 64'(rsp_valid), 64'd1);
        chk("t5_data", 64'(rsp_data), 64'(mk(read, 9, 1'b0)));
        tick();
        tick();
        chk("t5_err_sticky", 64'(proto_err), 64'd1);

        // 6: reset while offering with three queued entries
        req_sync = 1'b1;
        drive_cmd(mk(read, 21, 1'b0), 1'b1);
        tick();
        tick();
        chk("t6_out_pre", 64'(outstanding), 64'd1);
        req_sync = 1'b0;
        for (int i = 0; i < 4; i++) drive_cmd(mk(write, 50 + i, 1'b1), 1'b0);
        chk("t6_offering", 64'(req_notify), 64'd1);
        chk("t6_full_not", 64'(cmd_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_notify", 64'(req_notify), 64'd0);
        chk("t6_rst_ready", 64'(cmd_ready), 64'd1);
        chk("t6_rst_out", 64'(outstanding), 64'd0);
        chk("t6_rst_err", 64'(proto_err), 64'd0);
        tick();
        rst = 1'b0;
        req_sync = 1'b1;
        drive_cmd(mk(read, -1, 1'b1), 1'b1);
        chk("t6_post_edge1", 64'(req_notify), 64'd0);
        tick();
        chk("t6_post_notify", 64'(req_notify), 64'd1);
        chk("t6_post_req", 64'(req), 64'(mk(read, -1, 1'b1)));
        tick();
        chk("t6_post_out", 64'(outstanding), 64'd1);
        chk("t6_post_idle", 64'(req_notify), 64'd0);

        // Response carrying a write mode is a protocol error
        drive_rsp(mk(write, 2, 1'b0));
        tick();
        rsp_sync = 1'b0;
        chk("t6_mode_err", 64'(proto_err), 64'd1);
        chk("t6_mode_out", 64'(outstanding), 64'd0);
        tick();
        tick();

        // Every expected transfer must have been seen
        chk("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
